i2c_slave: RTL and testbench

I2C target (slave) that answers the master in `mod_I2C`. It sits on the same open-drain SDA/SCL pair, runs from the system clock, and oversamples the bus. It detects START/STOP, matches a fixed 7-bit address and ACKs it. Write bytes are delivered to local logic as one-cycle strobes; read bytes are serialised from a local byte input.

---
 rtl/i2c_slave_if.sv | 14 +
 rtl/i2c_slave.sv | 153 +++++++++++++++
 tb/tb_i2c_slave.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_slave_if.sv
// Local-side port bundle of the I2C target: byte handoff to/from local logic plus status.
// Strobes: rx_valid and tx_req are single-cycle pulses with no back-pressure; local logic must
// take rx_data on rx_valid and present the next tx_data before the following tx_req.
interface i2c_slave_if;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_req;
  logic       busy;
  logic [2:0] state;

  modport slave  (input tx_data, output rx_data, rx_valid, tx_req, busy, state);
  modport master (output tx_data, input rx_data, rx_valid, tx_req, busy, state);
endinterface

// File: rtl/i2c_slave.sv
// Oversampling I2C target: fixed 7-bit address, write bytes out as strobes, read bytes
// serialised from tx_data. SDA is open-drain (drives 0 or z), SCL is never stretched.
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h55
) (
    input  logic        clk,
    input  logic        rst,
    inout  wire         SDA,
    input  logic        SCL,
    i2c_slave_if.slave  lcl
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_ACK, WAIT_STOP
    } state_t;

    state_t     state_q, state_nxt;
    logic       scl_s1, scl_s2, scl_p, sda_s1, sda_s2, sda_p;
    logic       scl_rise, scl_fall, start_ev, stop_ev;
    logic [7:0] shreg;
    logic [7:0] sh_next;
    logic [2:0] bit_cnt;
    logic       rw;
    logic       ack_low, tx_drv, got_ack;
    logic       sda_oe, load_tx;
    logic [7:0] rx_data_q;
    logic       rx_valid_q, busy_q;

    // Sync flops idle high so reset never fabricates a START or STOP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_s1 <= 1'b1; scl_s2 <= 1'b1; scl_p <= 1'b1;
            sda_s1 <= 1'b1; sda_s2 <= 1'b1; sda_p <= 1'b1;
        end else begin
            scl_s1 <= SCL;    scl_s2 <= scl_s1; scl_p <= scl_s2;
            sda_s1 <= SDA;    sda_s2 <= sda_s1; sda_p <= sda_s2;
        end
    end

    assign scl_rise = scl_s2 & ~scl_p;
    assign scl_fall = ~scl_s2 & scl_p;
    assign start_ev = scl_s2 & scl_p & sda_p & ~sda_s2;
    assign stop_ev  = scl_s2 & scl_p & ~sda_p & sda_s2;
    assign sh_next  = {shreg[6:0], sda_s2};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        if (start_ev) begin
            state_nxt = ADDR;
        end else if (stop_ev) begin
            state_nxt = IDLE;
        end else begin
            case (state_q)
                ADDR:     if (scl_rise && bit_cnt == 3'd7)
                              state_nxt = (shreg[6:0] == SLAVE_ADDR) ? ADDR_ACK : WAIT_STOP;
                ADDR_ACK: if (scl_fall && ack_low) state_nxt = rw ? TX_DATA : RX_DATA;
                RX_DATA:  if (scl_rise && bit_cnt == 3'd7) state_nxt = RX_ACK;
                RX_ACK:   if (scl_fall && ack_low) state_nxt = RX_DATA;
                // bit_cnt wraps to 0 on the 8th rise, so the next fall ends the byte.
                TX_DATA:  if (scl_fall && bit_cnt == 3'd0) state_nxt = TX_ACK;
                TX_ACK: begin
                    if (scl_rise && sda_s2)       state_nxt = WAIT_STOP;
                    else if (scl_fall && got_ack) state_nxt = TX_DATA;
                end
                default:  state_nxt = state_q;
            endcase
        end
    end

    always_comb begin
        load_tx = (state_nxt == TX_DATA) && (state_q != TX_DATA);
        sda_oe  = ack_low | (tx_drv & ~shreg[7]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg      <= 8'h00;
            bit_cnt    <= 3'd0;
            rw         <= 1'b0;
            ack_low    <= 1'b0;
            tx_drv     <= 1'b0;
            got_ack    <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (start_ev || stop_ev) begin
                bit_cnt <= 3'd0;
                ack_low <= 1'b0;
                tx_drv  <= 1'b0;
                got_ack <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    ADDR: if (scl_rise) begin
                        shreg   <= sh_next;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rw <= sda_s2;
                            if (shreg[6:0] == SLAVE_ADDR) busy_q <= 1'b1;
                        end
                    end
                    ADDR_ACK, RX_ACK: if (scl_fall) begin
                        ack_low <= ~ack_low;
                        bit_cnt <= 3'd0;
                    end
                    RX_DATA: if (scl_rise) begin
                        shreg   <= sh_next;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rx_data_q  <= sh_next;
                            rx_valid_q <= 1'b1;
                        end
                    end
                    TX_DATA: begin
                        if (scl_rise) bit_cnt <= bit_cnt + 3'd1;
                        if (scl_fall) begin
                            if (bit_cnt == 3'd0) tx_drv <= 1'b0;
                            else                 shreg  <= {shreg[6:0], 1'b0};
                        end
                    end
                    TX_ACK: begin
                        if (scl_rise) begin
                            if (sda_s2) busy_q  <= 1'b0;
                            else        got_ack <= 1'b1;
                        end
                        if (scl_fall && got_ack) got_ack <= 1'b0;
                    end
                    default: ;
                endcase
                if (load_tx) begin
                    shreg   <= lcl.tx_data;
                    tx_drv  <= 1'b1;
                    bit_cnt <= 3'd0;
                end
            end
        end
    end

    assign SDA          = sda_oe ? 1'b0 : 1'bz;
    assign lcl.rx_data  = rx_data_q;
    assign lcl.rx_valid = rx_valid_q;
    assign lcl.tx_req   = load_tx;
    assign lcl.busy     = busy_q;
    assign lcl.state    = state_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: a bit-banged master on a pulled-up SDA line, with pulse monitors.
module tb_i2c_slave;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic m_scl = 1'b1;
  logic m_sda_oe = 1'b0;
  wire  sda;

  int n_tests = 0;
  int n_fail  = 0;
  int rxv_cycles = 0;
  int txreq_cycles = 0;
  int slave_low = 0;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT_STOP = 3'd7;

  pullup (sda);
  assign sda = m_sda_oe ? 1'b0 : 1'bz;

  i2c_slave_if lcl ();

  i2c_slave #(.SLAVE_ADDR(7'h55)) dut (
    .clk(clk),
    .rst(rst),
    .SDA(sda),
    .SCL(m_scl),
    .lcl(lcl)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (lcl.rx_valid === 1'b1) rxv_cycles++;
    if (lcl.tx_req === 1'b1) txreq_cycles++;
    if (!m_sda_oe && sda === 1'b0) slave_low++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, output logic seen);
    tick(8);
    m_sda_oe = ~b;
    tick(8);
    m_scl = 1'b1;
    tick(5);
    seen = sda;
    tick(5);
    m_scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] wb, output logic [7:0] rb);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      send_bit(wb[i], s);
      rb[i] = s;
    end
  endtask

  task automatic start_cond();
    tick(8);
    m_sda_oe = 1'b0;
    tick(8);
    m_scl = 1'b1;
    tick(8);
    m_sda_oe = 1'b1;
    tick(8);
    m_scl = 1'b0;
  endtask

  task automatic stop_cond();
    tick(8);
    m_sda_oe = 1'b1;
    tick(8);
    m_scl = 1'b1;
    tick(8);
    m_sda_oe = 1'b0;
    tick(8);
  endtask

  task automatic clear_mon();
    rxv_cycles = 0;
    txreq_cycles = 0;
    slave_low = 0;
  endtask

  initial begin
    logic [7:0] rb;
    logic ack;

    lcl.tx_data = 8'h00;
    tick(5);
    check("rst_rx_data", lcl.rx_data, 8'h00);
    check("rst_rx_valid", lcl.rx_valid, 1'b0);
    check("rst_tx_req", lcl.tx_req, 1'b0);
    check("rst_busy", lcl.busy, 1'b0);
    check("rst_sda", sda, 1'b1);
    check("rst_state", lcl.state, S_IDLE);
    rst = 1'b1;
    tick(10);

    // Write 0x3C to 0x55
    clear_mon();
    start_cond();
    send_byte(8'hAA, rb);
    send_bit(1'b1, ack);
    check("wr_addr_ack", ack, 1'b0);
    check("wr_busy", lcl.busy, 1'b1);
    send_byte(8'h3C, rb);
    send_bit(1'b1, ack);
    check("wr_data_ack", ack, 1'b0);
    stop_cond();
    check("wr_rx_data", lcl.rx_data, 8'h3C);
    check("wr_rxv_pulse", rxv_cycles, 1);
    check("wr_busy_after", lcl.busy, 1'b0);
    check("wr_state_idle", lcl.state, S_IDLE);

    // Wrong address
    clear_mon();
    start_cond();
    send_byte(8'h90, rb);
    send_bit(1'b1, ack);
    check("wa_nack", ack, 1'b1);
    check("wa_busy", lcl.busy, 1'b0);
    send_byte(8'h55, rb);
    send_bit(1'b1, ack);
    check("wa_nack2", ack, 1'b1);
    stop_cond();
    check("wa_never_low", slave_low, 0);
    check("wa_no_rxv", rxv_cycles, 0);

    // Read two bytes, master NACKs the second
    clear_mon();
    lcl.tx_data = 8'hA5;
    start_cond();
    send_byte(8'hAB, rb);
    send_bit(1'b1, ack);
    check("rd_addr_ack", ack, 1'b0);
    send_byte(8'hFF, rb);
    check("rd_byte0", rb, 8'hA5);
    lcl.tx_data = 8'h0F;
    send_bit(1'b0, ack);
    send_byte(8'hFF, rb);
    check("rd_byte1", rb, 8'h0F);
    send_bit(1'b1, ack);
    check("rd_nack_line", ack, 1'b1);
    tick(6);
    check("rd_sda_released", sda, 1'b1);
    check("rd_busy_cleared", lcl.busy, 1'b0);
    check("rd_wait_stop", lcl.state, S_WAIT_STOP);
    stop_cond();
    check("rd_txreq_pulses", txreq_cycles, 2);
    check("rd_state_idle", lcl.state, S_IDLE);

    // Repeated START mid-byte
    clear_mon();
    start_cond();
    send_byte(8'hAA, rb);
    send_bit(1'b1, ack);
    check("rs_addr1_ack", ack, 1'b0);
    send_bit(1'b1, ack);
    send_bit(1'b0, ack);
    send_bit(1'b1, ack);
    start_cond();
    send_byte(8'hAA, rb);
    send_bit(1'b1, ack);
    check("rs_addr2_ack", ack, 1'b0);
    send_byte(8'h77, rb);
    send_bit(1'b1, ack);
    check("rs_data_ack", ack, 1'b0);
    stop_cond();
    check("rs_rx_data", lcl.rx_data, 8'h77);
    check("rs_rxv_pulse", rxv_cycles, 1);

    // STOP after 4 data bits
    clear_mon();
    start_cond();
    send_byte(8'hAA, rb);
    send_bit(1'b1, ack);
    check("ms_addr_ack", ack, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0], ack);
    stop_cond();
    check("ms_no_rxv", rxv_cycles, 0);
    check("ms_state_idle", lcl.state, S_IDLE);
    check("ms_sda", sda, 1'b1);
    check("ms_rx_hold", lcl.rx_data, 8'h77);

    // Reset while driving a 0 data bit
    lcl.tx_data = 8'h3F;
    start_cond();
    send_byte(8'hAB, rb);
    send_bit(1'b1, ack);
    check("rr_addr_ack", ack, 1'b0);
    tick(8);
    check("rr_bit_low", sda, 1'b0);
    rst = 1'b0;
    #1;
    check("rr_sda_released", sda, 1'b1);
    check("rr_state", lcl.state, S_IDLE);
    check("rr_busy", lcl.busy, 1'b0);
    check("rr_rx_data", lcl.rx_data, 8'h00);
    check("rr_tx_req", lcl.tx_req, 1'b0);
    check("rr_rx_valid", lcl.rx_valid, 1'b0);
    tick(4);
    rst = 1'b1;
    tick(4);
    m_scl = 1'b1;
    tick(8);
    start_cond();
    send_byte(8'hAA, rb);
    send_bit(1'b1, ack);
    check("rr_reack", ack, 1'b0);
    stop_cond();
    check("rr_final_idle", lcl.state, S_IDLE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
